// File: rtl/memory_arbiter_if.sv
// Signal bundle between the core's fetch/data ports, memory_arbiter and the memory controller.
// The arbiter takes the slave view; the core plus memory environment takes the master view.
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_start;
  logic              inst_ready;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_flush;
  logic [DATA_W-1:0] inst_rdata;
  logic              inst_valid;

  logic              d_cmd_start;
  logic              d_cmd_write;
  logic              d_cmd_ready;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_wmask;
  logic [DATA_W-1:0] d_rdata;
  logic              d_rdata_valid;

  logic              mem_cmd_start;
  logic              mem_cmd_write;
  logic              mem_cmd_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdata_valid;

  modport slave (
    input  inst_start, inst_addr, inst_flush,
    input  d_cmd_start, d_cmd_write, d_addr, d_wdata, d_wmask,
    input  mem_cmd_ready, mem_rdata, mem_rdata_valid,
    output inst_ready, inst_rdata, inst_valid,
    output d_cmd_ready, d_rdata, d_rdata_valid,
    output mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output inst_start, inst_addr, inst_flush,
    output d_cmd_start, d_cmd_write, d_addr, d_wdata, d_wmask,
    output mem_cmd_ready, mem_rdata, mem_rdata_valid,
    input  inst_ready, inst_rdata, inst_valid,
    input  d_cmd_ready, d_rdata, d_rdata_valid,
    input  mem_cmd_start, mem_cmd_write, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one memory command port between the fetch and data ports: one-entry request latches,
// data-first arbitration with a starvation bound, read-return steering and fetch flush.
module memory_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  memory_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE_I = 3'd1;
  localparam logic [2:0] S_ISSUE_D = 3'd2;
  localparam logic [2:0] S_WAIT_I  = 3'd3;
  localparam logic [2:0] S_WAIT_D  = 3'd4;

  localparam int               CNT_W      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  logic [2:0]        r_state;
  logic [2:0]        w_state_next;

  logic              r_i_valid;
  logic [ADDR_W-1:0] r_i_addr;
  logic              r_d_valid;
  logic              r_d_write;
  logic [ADDR_W-1:0] r_d_addr;
  logic [DATA_W-1:0] r_d_wdata;
  logic [DATA_W-1:0] r_d_wmask;

  logic [CNT_W-1:0]  r_starve;
  logic              r_discard;

  logic              r_mem_start;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_mem_wmask;

  logic w_inst_ready;
  logic w_d_ready;
  logic w_i_accept;
  logic w_d_accept;
  logic w_i_req;
  logic w_starved;
  logic w_grant_i;
  logic w_grant_d;
  logic w_mem_accept;
  logic w_rdata_done;

  assign w_inst_ready = !r_i_valid && (r_state != S_ISSUE_I) && (r_state != S_WAIT_I);
  assign w_d_ready    = !r_d_valid && (r_state != S_ISSUE_D) && (r_state != S_WAIT_D);
  assign w_i_accept   = bus.inst_start && w_inst_ready;
  assign w_d_accept   = bus.d_cmd_start && w_d_ready;

  // A fetch being flushed this cycle must not be granted; its latch is cleared instead.
  assign w_i_req      = r_i_valid && !bus.inst_flush;
  assign w_starved    = (STARVE_LIMIT != 0) && (r_starve == STARVE_MAX);
  assign w_grant_i    = (r_state == S_IDLE) && w_i_req && (!r_d_valid || w_starved);
  assign w_grant_d    = (r_state == S_IDLE) && r_d_valid && (!w_i_req || !w_starved);
  assign w_mem_accept = r_mem_start && bus.mem_cmd_ready;
  assign w_rdata_done = ((r_state == S_WAIT_I) || (r_state == S_WAIT_D)) && bus.mem_rdata_valid;

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_i)      w_state_next = S_ISSUE_I;
        else if (w_grant_d) w_state_next = S_ISSUE_D;
      end
      S_ISSUE_I: if (w_mem_accept) w_state_next = S_WAIT_I;
      S_ISSUE_D: if (w_mem_accept) w_state_next = r_mem_write ? S_IDLE : S_WAIT_D;
      S_WAIT_I,
      S_WAIT_D:  if (bus.mem_rdata_valid) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
      r_starve    <= '0;
      r_discard   <= 1'b0;
      r_mem_start <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_i_accept)                                 r_i_valid <= 1'b1;
      else if (bus.inst_flush && r_state != S_ISSUE_I) r_i_valid <= 1'b0;
      else if (r_state == S_ISSUE_I && w_mem_accept)  r_i_valid <= 1'b0;

      if (w_d_accept)                                r_d_valid <= 1'b1;
      else if (r_state == S_ISSUE_D && w_mem_accept) r_d_valid <= 1'b0;

      // An issued fetch cannot be withdrawn; its data is dropped when it comes back.
      if (w_rdata_done)
        r_discard <= 1'b0;
      else if (bus.inst_flush && (r_state == S_ISSUE_I || r_state == S_WAIT_I))
        r_discard <= 1'b1;

      if (!r_i_valid || w_grant_i)
        r_starve <= '0;
      else if (w_grant_d && r_starve != STARVE_MAX)
        r_starve <= r_starve + CNT_W'(1);

      if (w_grant_i) begin
        r_mem_start <= 1'b1;
        r_mem_write <= 1'b0;
        r_mem_addr  <= r_i_addr;
        r_mem_wdata <= '0;
        r_mem_wmask <= '0;
      end else if (w_grant_d) begin
        r_mem_start <= 1'b1;
        r_mem_write <= r_d_write;
        r_mem_addr  <= r_d_addr;
        r_mem_wdata <= r_d_wdata;
        r_mem_wmask <= r_d_wmask;
      end else if (w_mem_accept) begin
        r_mem_start <= 1'b0;
      end
    end
  end

  // NOTE: latch payloads are only read while their valid bit is set, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_i_accept) r_i_addr <= bus.inst_addr;
    if (w_d_accept) begin
      r_d_write <= bus.d_cmd_write;
      r_d_addr  <= bus.d_addr;
      r_d_wdata <= bus.d_wdata;
      r_d_wmask <= bus.d_wmask;
    end
  end

  assign bus.inst_ready    = w_inst_ready;
  assign bus.d_cmd_ready   = w_d_ready;
  assign bus.inst_rdata    = bus.mem_rdata;
  assign bus.d_rdata       = bus.mem_rdata;
  assign bus.inst_valid    = (r_state == S_WAIT_I) && bus.mem_rdata_valid && !r_discard;
  assign bus.d_rdata_valid = (r_state == S_WAIT_D) && bus.mem_rdata_valid;
  assign bus.mem_cmd_start = r_mem_start;
  assign bus.mem_cmd_write = r_mem_write;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_wdata     = r_mem_wdata;
  assign bus.mem_wmask     = r_mem_wmask;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int STARVE_LIMIT = 4;

  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_e;

  typedef struct {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
  } req_t;

  logic clk;
  logic rst;

  memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  memory_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Stimulus for the next cycle
  logic        s_rst, s_inst_start, s_inst_flush, s_d_start, s_d_write, s_mem_ready, s_rvalid;
  logic [31:0] s_inst_addr, s_d_addr, s_d_wdata, s_d_wmask, s_rdata;

  // Reference model: pending request per port plus the one command owning the memory port
  req_t        m_i, m_d;
  owner_e      m_own;
  logic        m_sent;
  logic        m_discard;
  int          m_starve;
  int          m_lat;
  logic        m_cmd_write;
  logic        m_wd_known;
  logic [31:0] m_cmd_addr, m_cmd_wdata, m_cmd_wmask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_i         = '{valid: 1'b0, write: 1'b0, addr: '0, wdata: '0, wmask: '0};
    m_d         = '{valid: 1'b0, write: 1'b0, addr: '0, wdata: '0, wmask: '0};
    m_own       = OWN_NONE;
    m_sent      = 1'b0;
    m_discard   = 1'b0;
    m_starve    = 0;
    m_lat       = 0;
    m_cmd_write = 1'b0;
    m_cmd_addr  = '0;
    m_cmd_wdata = '0;
    m_cmd_wmask = '0;
    m_wd_known  = 1'b1;
  endtask

  task automatic idle_stim();
    s_rst        = 1'b0;
    s_inst_start = 1'b0;
    s_inst_flush = 1'b0;
    s_d_start    = 1'b0;
    s_rvalid     = 1'b0;
    s_mem_ready  = 1'b1;
  endtask

  task automatic apply_stim();
    rst                 = s_rst;
    bus.inst_start      = s_inst_start;
    bus.inst_addr       = s_inst_addr;
    bus.inst_flush      = s_inst_flush;
    bus.d_cmd_start     = s_d_start;
    bus.d_cmd_write     = s_d_write;
    bus.d_addr          = s_d_addr;
    bus.d_wdata         = s_d_wdata;
    bus.d_wmask         = s_d_wmask;
    bus.mem_cmd_ready   = s_mem_ready;
    bus.mem_rdata       = s_rdata;
    bus.mem_rdata_valid = s_rvalid;
  endtask

  task automatic check_outputs();
    logic e_iready, e_dready, e_start, e_ivalid, e_dvalid, waiting;
    waiting  = (m_own != OWN_NONE) && m_sent;
    e_iready = !m_i.valid && (m_own != OWN_I);
    e_dready = !m_d.valid && (m_own != OWN_D);
    e_start  = (m_own != OWN_NONE) && !m_sent;
    e_ivalid = waiting && (m_own == OWN_I) && s_rvalid && !m_discard;
    e_dvalid = waiting && (m_own == OWN_D) && s_rvalid;
    check("inst_ready",    32'(bus.inst_ready),    32'(e_iready));
    check("d_cmd_ready",   32'(bus.d_cmd_ready),   32'(e_dready));
    check("inst_valid",    32'(bus.inst_valid),    32'(e_ivalid));
    check("d_rdata_valid", 32'(bus.d_rdata_valid), 32'(e_dvalid));
    check("mem_cmd_start", 32'(bus.mem_cmd_start), 32'(e_start));
    check("mem_cmd_write", 32'(bus.mem_cmd_write), 32'(m_cmd_write));
    check("mem_addr",      bus.mem_addr,           m_cmd_addr);
    if (m_wd_known) begin
      check("mem_wdata", bus.mem_wdata, m_cmd_wdata);
      check("mem_wmask", bus.mem_wmask, m_cmd_wmask);
    end
    if (e_ivalid) check("inst_rdata", bus.inst_rdata, s_rdata);
    if (e_dvalid) check("d_rdata",    bus.d_rdata,    s_rdata);
  endtask

  // Advances the model across the coming clock edge using this cycle's inputs.
  task automatic model_edge();
    owner_e own0;
    logic   sent0, iv0, dv0, i_acc, d_acc, i_cand, d_cand, pick_i, granted_i, granted_d;
    if (s_rst) begin
      model_reset();
      return;
    end
    own0      = m_own;
    sent0     = m_sent;
    iv0       = m_i.valid;
    dv0       = m_d.valid;
    i_acc     = s_inst_start && !iv0 && (own0 != OWN_I);
    d_acc     = s_d_start && !dv0 && (own0 != OWN_D);
    granted_i = 1'b0;
    granted_d = 1'b0;

    if (own0 == OWN_NONE) begin
      i_cand = iv0 && !s_inst_flush;
      d_cand = dv0;
      if (i_cand && d_cand) pick_i = (STARVE_LIMIT != 0) && (m_starve >= STARVE_LIMIT);
      else                  pick_i = i_cand;
      granted_i = i_cand && pick_i;
      granted_d = d_cand && !pick_i;
      if (granted_i) begin
        m_own       = OWN_I;
        m_sent      = 1'b0;
        m_cmd_write = 1'b0;
        m_cmd_addr  = m_i.addr;
        m_wd_known  = 1'b0;
      end else if (granted_d) begin
        m_own       = OWN_D;
        m_sent      = 1'b0;
        m_cmd_write = m_d.write;
        m_cmd_addr  = m_d.addr;
        m_cmd_wdata = m_d.wdata;
        m_cmd_wmask = m_d.wmask;
        m_wd_known  = 1'b1;
      end
    end else if (!sent0) begin
      if (s_mem_ready) begin
        m_sent = 1'b1;
        if (own0 == OWN_I) m_i.valid = 1'b0;
        else               m_d.valid = 1'b0;
        if (own0 == OWN_D && m_cmd_write) m_own = OWN_NONE;
        else                              m_lat = $urandom_range(0, 3);
      end
    end else if (s_rvalid) begin
      m_own = OWN_NONE;
    end

    if (own0 != OWN_NONE && sent0 && s_rvalid) m_discard = 1'b0;
    else if (s_inst_flush && own0 == OWN_I)   m_discard = 1'b1;

    if (!iv0 || granted_i)                           m_starve = 0;
    else if (granted_d && m_starve < STARVE_LIMIT)   m_starve++;

    if (s_inst_flush && iv0 && own0 != OWN_I) m_i.valid = 1'b0;
    if (i_acc) begin
      m_i.valid = 1'b1;
      m_i.addr  = s_inst_addr;
    end
    if (d_acc) m_d = '{valid: 1'b1, write: s_d_write, addr: s_d_addr, wdata: s_d_wdata, wmask: s_d_wmask};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    apply_stim();
    @(negedge clk);
    check_outputs();
    model_edge();
  endtask

  task automatic gen_random_stim();
    s_rst        = ($urandom_range(0, 599) == 0);
    s_inst_start = ($urandom_range(0, 2) == 0);
    s_inst_addr  = $urandom;
    s_inst_flush = ($urandom_range(0, 11) == 0);
    s_d_start    = ($urandom_range(0, 1) == 0);
    s_d_write    = ($urandom_range(0, 1) == 1);
    s_d_addr     = $urandom;
    s_d_wdata    = $urandom;
    s_d_wmask    = $urandom;
    s_mem_ready  = ($urandom_range(0, 2) != 0);
    s_rdata      = $urandom;
    if (m_own != OWN_NONE && m_sent) begin
      if (m_lat == 0) s_rvalid = 1'b1;
      else begin
        s_rvalid = 1'b0;
        m_lat--;
      end
    end else begin
      s_rvalid = ($urandom_range(0, 9) == 0);
    end
  endtask

  initial begin
    s_inst_addr = '0; s_d_write = 1'b0; s_d_addr = '0; s_d_wdata = '0; s_d_wmask = '0; s_rdata = '0;
    idle_stim();
    s_rst = 1'b1;
    apply_stim();
    model_reset();
    step();
    step();

    // Reset state
    idle_stim();
    step();
    check("rst inst_ready",    32'(bus.inst_ready),    32'd1);
    check("rst d_cmd_ready",   32'(bus.d_cmd_ready),   32'd1);
    check("rst mem_cmd_start", 32'(bus.mem_cmd_start), 32'd0);

    // Single fetch, data returned three cycles after accept
    s_inst_start = 1'b1; s_inst_addr = 32'h0000_0100; step();
    s_inst_start = 1'b0; step();
    step();
    check("t1 cmd_start", 32'(bus.mem_cmd_start), 32'd1);
    check("t1 cmd_addr",  bus.mem_addr,           32'h0000_0100);
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; step();
    check("t1 inst_valid",    32'(bus.inst_valid),    32'd1);
    check("t1 inst_rdata",    bus.inst_rdata,         32'hDEAD_BEEF);
    check("t1 d_rdata_valid", 32'(bus.d_rdata_valid), 32'd0);
    s_rvalid = 1'b0; step();
    check("t1 inst_ready", 32'(bus.inst_ready), 32'd1);
    check("t1 valid_drop", 32'(bus.inst_valid), 32'd0);

    // Simultaneous fetch and data write: the write goes first
    s_inst_start = 1'b1; s_inst_addr = 32'h0000_0200;
    s_d_start = 1'b1; s_d_write = 1'b1; s_d_addr = 32'h0000_0300;
    s_d_wdata = 32'h1234_5678; s_d_wmask = 32'hFFFF_FFFF; step();
    s_inst_start = 1'b0; s_d_start = 1'b0; step();
    step();
    check("t2 first_write", 32'(bus.mem_cmd_write), 32'd1);
    check("t2 first_addr",  bus.mem_addr,           32'h0000_0300);
    check("t2 first_wdata", bus.mem_wdata,          32'h1234_5678);
    step();
    check("t2 d_ready_after_write", 32'(bus.d_cmd_ready), 32'd1);
    step();
    check("t2 second_write", 32'(bus.mem_cmd_write), 32'd0);
    check("t2 second_addr",  bus.mem_addr,           32'h0000_0200);
    s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D; step();
    check("t2 inst_valid", 32'(bus.inst_valid), 32'd1);
    s_rvalid = 1'b0; step();

    // Flush while waiting for fetch data
    s_inst_start = 1'b1; s_inst_addr = 32'h0000_0400; step();
    s_inst_start = 1'b0; step();
    step();
    s_inst_flush = 1'b1; step();
    s_inst_flush = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D; step();
    check("t4 no_inst_valid", 32'(bus.inst_valid), 32'd0);
    check("t4 ready_low",     32'(bus.inst_ready), 32'd0);
    s_rvalid = 1'b0; step();
    check("t4 ready_back", 32'(bus.inst_ready), 32'd1);

    // Memory stalls the data write; requester fields change meanwhile
    s_mem_ready = 1'b0;
    s_d_start = 1'b1; s_d_write = 1'b1; s_d_addr = 32'h0000_0500;
    s_d_wdata = 32'hA5A5_A5A5; s_d_wmask = 32'h0000_FFFF; step();
    s_d_addr = $urandom; step();
    for (int k = 0; k < 10; k++) begin
      s_d_addr = $urandom; s_d_wdata = $urandom; s_d_wmask = $urandom;
      step();
      check("t5 hold_start", 32'(bus.mem_cmd_start), 32'd1);
      check("t5 hold_addr",  bus.mem_addr,           32'h0000_0500);
      check("t5 hold_wdata", bus.mem_wdata,          32'hA5A5_A5A5);
      check("t5 hold_wmask", bus.mem_wmask,          32'h0000_FFFF);
    end
    s_d_start = 1'b0; s_mem_ready = 1'b1; step();
    step();

    // Reset while a data read is outstanding; the late return is ignored
    s_d_start = 1'b1; s_d_write = 1'b0; s_d_addr = 32'h0000_0600; step();
    s_d_start = 1'b0; step();
    step();
    s_rst = 1'b1; step();
    s_rst = 1'b0; step();
    check("t6 mem_cmd_start", 32'(bus.mem_cmd_start), 32'd0);
    check("t6 mem_cmd_write", 32'(bus.mem_cmd_write), 32'd0);
    check("t6 mem_addr",      bus.mem_addr,           32'd0);
    check("t6 mem_wdata",     bus.mem_wdata,          32'd0);
    check("t6 mem_wmask",     bus.mem_wmask,          32'd0);
    check("t6 inst_ready",    32'(bus.inst_ready),    32'd1);
    check("t6 d_cmd_ready",   32'(bus.d_cmd_ready),   32'd1);
    s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA; step();
    check("t6 no_d_valid", 32'(bus.d_rdata_valid), 32'd0);
    s_rvalid = 1'b0; step();

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      gen_random_stim();
      step();
    end
    idle_stim();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
